// File: rtl/stage_sequence_checker.sv
// stage_sequence_checker: monitors ControlUnit stage strobes, tracks the legal instruction sequence,
// counts retirements by class and latches the first protocol violation.
module stage_sequence_checker #(
  parameter int CNT_W        = 16,
  parameter bit ALLOW_BUBBLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             top_en,
  input  logic             IF,
  input  logic             ID,
  input  logic             REG,
  input  logic             EX,
  input  logic             MEM,
  input  logic             WB,
  input  logic             JU,
  input  logic             BR,
  output logic             instr_done,
  output logic [CNT_W-1:0] alu_count,
  output logic [CNT_W-1:0] ju_count,
  output logic [CNT_W-1:0] br_count,
  output logic [2:0]       exp_stage,
  output logic             err,
  output logic [2:0]       err_code
);
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_REG = 3'd2,
    S_DEC = 3'd3,
    S_MEM = 3'd4,
    S_WB  = 3'd5
  } state_t;

  state_t           r_state, w_next;
  logic [7:0]       w_strb;
  logic             w_multi, w_any, w_legal, w_adv;
  logic [2:0]       w_code;
  logic             w_ret_alu, w_ret_ju, w_ret_br;
  logic             r_done, r_err;
  logic [2:0]       r_code;
  logic [CNT_W-1:0] r_alu, r_ju, r_br;

  assign w_strb  = {BR, JU, WB, MEM, EX, REG, ID, IF};
  assign w_any   = |w_strb;
  assign w_multi = (w_strb & (w_strb - 8'd1)) != 8'd0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  // A single strobe is legal only if it is the one the current state is waiting for.
  always_comb begin
    w_legal = (r_state == S_IF)  ? IF :
              (r_state == S_ID)  ? ID :
              (r_state == S_REG) ? REG :
              (r_state == S_DEC) ? (EX | JU | BR) :
              (r_state == S_MEM) ? MEM :
              (r_state == S_WB)  ? WB : 1'b0;
    w_code  = w_multi              ? 3'd1 :
              (!top_en && w_any)   ? 3'd3 :
              !top_en              ? 3'd0 :
              !w_any               ? (ALLOW_BUBBLE ? 3'd0 : 3'd4) :
              !w_legal             ? 3'd2 : 3'd0;
    w_adv   = top_en && w_any && !w_multi && w_legal;
    w_next  = (w_code != 3'd0)     ? S_IF :
              !w_adv               ? r_state :
              (r_state == S_IF)    ? S_ID :
              (r_state == S_ID)    ? S_REG :
              (r_state == S_REG)   ? S_DEC :
              (r_state == S_DEC)   ? (EX ? S_MEM : S_IF) :
              (r_state == S_MEM)   ? S_WB : S_IF;
  end

  always_comb begin
    w_ret_alu = w_adv && (r_state == S_WB);
    w_ret_ju  = w_adv && (r_state == S_DEC) && JU;
    w_ret_br  = w_adv && (r_state == S_DEC) && BR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_code <= 3'd0;
      r_alu  <= '0;
      r_ju   <= '0;
      r_br   <= '0;
    end else begin
      r_done <= w_ret_alu | w_ret_ju | w_ret_br;
      if (w_code != 3'd0) r_err <= 1'b1;
      if (w_code != 3'd0 && !r_err) r_code <= w_code;
      if (w_ret_alu && !(&r_alu)) r_alu <= r_alu + 1'b1;
      if (w_ret_ju  && !(&r_ju))  r_ju  <= r_ju + 1'b1;
      if (w_ret_br  && !(&r_br))  r_br  <= r_br + 1'b1;
    end
  end

  assign instr_done = r_done;
  assign alu_count  = r_alu;
  assign ju_count   = r_ju;
  assign br_count   = r_br;
  assign exp_stage  = r_state;
  assign err        = r_err;
  assign err_code   = r_code;
endmodule

// File: tb/tb_stage_sequence_checker.sv
// tb_stage_sequence_checker: table vectors, corner sequences and random stimulus against a path-position model.
module tb_stage_sequence_checker;
  localparam logic [7:0] N = 8'd0, F = 8'd1, D = 8'd2, R = 8'd4, X = 8'd8;
  localparam logic [7:0] M = 8'd16, W = 8'd32, J = 8'd64, B = 8'd128;

  logic clk = 1'b0, rst = 1'b1, top_en = 1'b0;
  logic [7:0] s = 8'd0;
  always #5 clk = ~clk;

  logic done0, done1, done2, err0, err1, err2;
  logic [15:0] alu0, ju0, br0, alu2, ju2, br2;
  logic [1:0] alu1, ju1, br1;
  logic [2:0] st0, st1, st2, code0, code1, code2;

  stage_sequence_checker #(.CNT_W(16), .ALLOW_BUBBLE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .top_en(top_en), .IF(s[0]), .ID(s[1]), .REG(s[2]), .EX(s[3]),
    .MEM(s[4]), .WB(s[5]), .JU(s[6]), .BR(s[7]), .instr_done(done0), .alu_count(alu0),
    .ju_count(ju0), .br_count(br0), .exp_stage(st0), .err(err0), .err_code(code0));
  stage_sequence_checker #(.CNT_W(2), .ALLOW_BUBBLE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .top_en(top_en), .IF(s[0]), .ID(s[1]), .REG(s[2]), .EX(s[3]),
    .MEM(s[4]), .WB(s[5]), .JU(s[6]), .BR(s[7]), .instr_done(done1), .alu_count(alu1),
    .ju_count(ju1), .br_count(br1), .exp_stage(st1), .err(err1), .err_code(code1));
  stage_sequence_checker #(.CNT_W(16), .ALLOW_BUBBLE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .top_en(top_en), .IF(s[0]), .ID(s[1]), .REG(s[2]), .EX(s[3]),
    .MEM(s[4]), .WB(s[5]), .JU(s[6]), .BR(s[7]), .instr_done(done2), .alu_count(alu2),
    .ju_count(ju2), .br_count(br2), .exp_stage(st2), .err(err2), .err_code(code2));

  // Model: position along an instruction path; ALU path strobe index equals position, JU/BR end at 3.
  typedef struct {int pos; int alu; int ju; int br; bit err; int code; bit done;} mdl_t;
  typedef struct {bit r; bit en; logic [7:0] v; int st; bit e; int c; bit d; int alu; int ju; int br;} vec_t;

  mdl_t m0, m1;
  int vectors = 0, miscompares = 0;

  function automatic mdl_t mstep(mdl_t m, bit r, bit en, logic [7:0] v, bit bubble);
    mdl_t n;
    int k, idx, c;
    n = m;
    n.done = 1'b0;
    if (r) begin
      n = '{default:0};
      return n;
    end
    k = $countones(v);
    idx = 0;
    c = 0;
    for (int i = 0; i < 8; i++) if (v[i]) idx = i;
    if (k > 1) c = 1;
    else if (!en) c = (k == 1) ? 3 : 0;
    else if (k == 0) c = bubble ? 0 : 4;
    else if (!(idx == m.pos || (m.pos == 3 && idx >= 6))) c = 2;
    if (c != 0) begin
      n.err = 1'b1;
      if (!m.err) n.code = c;
      n.pos = 0;
    end else if (en && k == 1) begin
      if (idx == 5)      begin n.alu++; n.done = 1'b1; n.pos = 0; end
      else if (idx == 6) begin n.ju++;  n.done = 1'b1; n.pos = 0; end
      else if (idx == 7) begin n.br++;  n.done = 1'b1; n.pos = 0; end
      else n.pos = m.pos + 1;
    end
    return n;
  endfunction

  function automatic int sat(int x, int mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_models();
    check("d0.stage", st0, m0.pos);   check("d0.err", err0, m0.err);
    check("d0.code", code0, m0.code); check("d0.done", done0, m0.done);
    check("d0.alu", alu0, sat(m0.alu, 65535)); check("d0.ju", ju0, sat(m0.ju, 65535));
    check("d0.br", br0, sat(m0.br, 65535));
    check("d1.stage", st1, m0.pos);   check("d1.code", code1, m0.code);
    check("d1.done", done1, m0.done); check("d1.alu", alu1, sat(m0.alu, 3));
    check("d1.ju", ju1, sat(m0.ju, 3)); check("d1.br", br1, sat(m0.br, 3));
    check("d2.stage", st2, m1.pos);   check("d2.err", err2, m1.err);
    check("d2.code", code2, m1.code); check("d2.done", done2, m1.done);
    check("d2.alu", alu2, sat(m1.alu, 65535)); check("d2.ju", ju2, sat(m1.ju, 65535));
    check("d2.br", br2, sat(m1.br, 65535));
  endtask

  task automatic step(input bit r, input bit en, input logic [7:0] v);
    rst = r;
    top_en = en;
    s = v;
    @(posedge clk);
    m0 = mstep(m0, r, en, v, 1'b0);
    m1 = mstep(m1, r, en, v, 1'b1);
    #1;
    cmp_models();
  endtask

  function automatic logic [7:0] legal_strobe(int p);
    int k;
    k = $urandom_range(0, 2);
    if (p != 3) return 8'd1 << p;
    return (k == 0) ? X : (k == 1) ? J : B;
  endfunction

  vec_t tbl[$];
  int pulses;

  initial begin
    m0 = '{default:0};
    m1 = '{default:0};
    tbl.push_back('{1, 0, N, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, F, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, D, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, R, 3, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, X, 4, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, M, 5, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, W, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 1, F, 1, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 1, D, 2, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 1, R, 3, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 1, J, 0, 0, 0, 1, 1, 1, 0});
    tbl.push_back('{0, 1, F, 1, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 1, D, 2, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 1, R, 3, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 1, B, 0, 0, 0, 1, 1, 1, 1});
    tbl.push_back('{1, 0, N, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, F, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, D, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, X, 0, 1, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 1, F, 1, 1, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 1, D, 2, 1, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 1, R, 3, 1, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 1, X, 4, 1, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 1, M, 5, 1, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 1, W, 0, 1, 2, 1, 1, 0, 0});
    tbl.push_back('{1, 0, N, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, F | D, 0, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, N, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, F, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, D, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, R, 3, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, X | J, 0, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, N, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, F, 0, 1, 3, 0, 0, 0, 0});
    tbl.push_back('{1, 0, N, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, N, 0, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{1, 0, N, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, F, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, X, 0, 1, 3, 0, 0, 0, 0});
    tbl.push_back('{1, 0, N, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, F, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, D, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, R, 3, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, N, 3, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, J, 0, 0, 0, 1, 0, 1, 0});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].en, tbl[i].v);
      check("tbl.stage", st0, tbl[i].st);
      check("tbl.err", err0, tbl[i].e);
      check("tbl.code", code0, tbl[i].c);
      check("tbl.done", done0, tbl[i].d);
      check("tbl.alu", alu0, tbl[i].alu);
      check("tbl.ju", ju0, tbl[i].ju);
      check("tbl.br", br0, tbl[i].br);
    end

    // Saturation on the narrow instance, then reset in the middle of an instruction.
    step(1, 0, N);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, F); step(0, 1, D); step(0, 1, R); step(0, 1, X); step(0, 1, M); step(0, 1, W);
      pulses += done1;
      step(0, 0, N);
      pulses += done1;
    end
    check("sat.alu1", alu1, 3);
    check("sat.alu0", alu0, 5);
    check("sat.pulses", pulses, 5);
    check("sat.err1", err1, 0);
    step(0, 1, F);
    step(1, 1, D);
    check("rst.stage", st1, 0);
    check("rst.alu", alu1, 0);
    check("rst.done", done1, 0);
    check("rst.err", err1, 0);
    check("rst.code", code1, 0);

    for (int i = 0; i < 3000; i++) begin
      int p;
      logic [7:0] v;
      p = $urandom_range(0, 99);
      v = (p < 70) ? legal_strobe(m0.pos) : (p < 85) ? N : 8'($urandom);
      step($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
